// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - 4-requester round-robin bus arbiter with per-grant timeout
module bus_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t     state_q, state_n;
    logic [3:0] grant_q, grant_n;
    logic [1:0] sel_q, sel_n;
    logic [1:0] last_q, last_n;
    logic [7:0] cnt_q, cnt_n;
    logic       timeout_q, timeout_n;

    logic [3:0] req_m;
    logic [1:0] win;
    logic [1:0] idx;
    logic       found;
    logic       expire;
    logic       release_c;

    // State register: every output is taken straight from a flop, so req/done never reach a port combinationally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            grant_q   <= 4'b0000;
            sel_q     <= 2'd0;
            last_q    <= 2'd3;
            cnt_q     <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_n;
            grant_q   <= grant_n;
            sel_q     <= sel_n;
            last_q    <= last_n;
            cnt_q     <= cnt_n;
            timeout_q <= timeout_n;
        end
    end

    // Round-robin search starting after the last winner; the releasing owner is masked so it cannot win twice in a row
    always_comb begin
        req_m = req;
        if (state_q == BUSY) begin
            req_m = req & ~grant_q;
        end
        found = 1'b0;
        win   = last_q;
        idx   = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            idx = last_q + 2'(i);
            if (!found && req_m[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // Next-state logic: grant on request, hold while busy, release on done / abort / expiry
    always_comb begin
        state_n   = state_q;
        grant_n   = grant_q;
        sel_n     = sel_q;
        last_n    = last_q;
        cnt_n     = cnt_q;
        timeout_n = 1'b0;
        expire    = (state_q == BUSY) && (cnt_q == CNT_LAST);
        release_c = done || !req[sel_q] || expire;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_n = BUSY;
                    grant_n = 4'b0001 << win;
                    sel_n   = win;
                    last_n  = win;
                    cnt_n   = 8'd0;
                end
            end
            BUSY: begin
                if (release_c) begin
                    // a pulse only when the owner was still asking and done did not arrive in time
                    timeout_n = expire && !done && req[sel_q];
                    if (found) begin
                        grant_n = 4'b0001 << win;
                        sel_n   = win;
                        last_n  = win;
                        cnt_n   = 8'd0;
                    end else begin
                        state_n = IDLE;
                        grant_n = 4'b0000;
                        sel_n   = 2'd0;
                        cnt_n   = 8'd0;
                    end
                end else begin
                    cnt_n = cnt_q + 8'd1;
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = 4'b0000;
                sel_n   = 2'd0;
                cnt_n   = 8'd0;
            end
        endcase
    end

    // Output decode from registered state only
    always_comb begin
        grant   = grant_q;
        sel     = sel_q;
        busy    = |grant_q;
        timeout = timeout_q;
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed self-checking bench for bus_arbiter
module tb_bus_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
    logic       timeout;

    int vectors;
    int errors;

    bus_arbiter #(.TIMEOUT(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .done    (done),
        .grant   (grant),
        .sel     (sel),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Structural invariants on every cycle: one-hot grant, sel encodes grant, busy is OR of grant
    always @(negedge clk) begin
        logic [1:0] enc;
        enc = 2'd0;
        for (int i = 0; i < 4; i++) if (grant[i]) enc = 2'(i);
        vectors++;
        if ((grant & (grant - 4'd1)) !== 4'b0000) begin
            errors++;
            $display("FAIL onehot: grant=%b is not one-hot or zero", grant);
        end
        vectors++;
        if (sel !== enc) begin
            errors++;
            $display("FAIL sel_enc: sel=%0d required %0d for grant=%b", sel, enc, grant);
        end
        vectors++;
        if (busy !== (|grant)) begin
            errors++;
            $display("FAIL busy_enc: busy=%b required %b for grant=%b", busy, |grant, grant);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic [3:0] g, input logic [1:0] s,
                              input logic b, input logic t);
        vectors++;
        if (grant !== g || sel !== s || busy !== b || timeout !== t) begin
            errors++;
            $display("FAIL %s: grant=%b sel=%0d busy=%b timeout=%b required grant=%b sel=%0d busy=%b timeout=%b",
                     name, grant, sel, busy, timeout, g, s, b, t);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req   = 4'b1111;
        done  = 1'b0;
        tick();
        tick();
        expect_out("reset_hold", 4'b0000, 2'd0, 1'b0, 1'b0);
        reset = 1'b0;
        req   = 4'b0000;
        tick();
        expect_out("reset_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
    endtask

    task automatic test_round_robin();
        logic [3:0] g;
        req = 4'b1111;
        tick();
        expect_out("rr_first", 4'b0001, 2'd0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            g = 4'b0001 << k;
            tick();
            expect_out("rr_hold1", g, 2'(k), 1'b1, 1'b0);
            req = 4'b1111;
            tick();
            expect_out("rr_hold2", g, 2'(k), 1'b1, 1'b0);
            done = 1'b1;
            tick();
            done = 1'b0;
            g = 4'b0001 << ((k + 1) % 4);
            expect_out("rr_next", g, 2'((k + 1) % 4), 1'b1, 1'b0);
        end
        req = 4'b0000;
        tick();
        expect_out("rr_abort_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
    endtask

    task automatic test_sole_requester();
        req = 4'b0100;
        tick();
        expect_out("sole_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
        done = 1'b1;
        tick();
        done = 1'b0;
        expect_out("sole_masked", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        expect_out("sole_regrant", 4'b0100, 2'd2, 1'b1, 1'b0);
        req = 4'b0000;
        tick();
        expect_out("sole_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
    endtask

    task automatic test_done_idle();
        done = 1'b1;
        tick();
        done = 1'b0;
        expect_out("done_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
    endtask

    task automatic test_timeout();
        req = 4'b0010;
        for (int c = 0; c < 4; c++) begin
            tick();
            expect_out("to_held", 4'b0010, 2'd1, 1'b1, 1'b0);
        end
        tick();
        expect_out("to_pulse", 4'b0000, 2'd0, 1'b0, 1'b1);
        tick();
        expect_out("to_regrant", 4'b0010, 2'd1, 1'b1, 1'b0);
        req = 4'b0000;
        tick();
        expect_out("to_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
    endtask

    task automatic test_abort();
        req = 4'b0100;
        tick();
        expect_out("ab_grant2", 4'b0100, 2'd2, 1'b1, 1'b0);
        req = 4'b1100;
        tick();
        expect_out("ab_hold", 4'b0100, 2'd2, 1'b1, 1'b0);
        req = 4'b1000;
        tick();
        expect_out("ab_move3", 4'b1000, 2'd3, 1'b1, 1'b0);
        req = 4'b0000;
        tick();
        expect_out("ab_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
    endtask

    task automatic test_done_expiry();
        req = 4'b0001;
        for (int c = 0; c < 4; c++) begin
            tick();
            expect_out("de_held", 4'b0001, 2'd0, 1'b1, 1'b0);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        expect_out("de_release", 4'b0000, 2'd0, 1'b0, 1'b0);
        req = 4'b0000;
        tick();
        expect_out("de_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        req = 4'b0010;
        tick();
        expect_out("rm_grant", 4'b0010, 2'd1, 1'b1, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        expect_out("rm_async", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        expect_out("rm_held", 4'b0000, 2'd0, 1'b0, 1'b0);
        reset = 1'b0;
        req   = 4'b1001;
        tick();
        expect_out("rm_prio0", 4'b0001, 2'd0, 1'b1, 1'b0);
        req = 4'b0000;
        tick();
        expect_out("rm_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        reset   = 1'b1;
        req     = 4'b0000;
        done    = 1'b0;
        test_reset();
        test_round_robin();
        test_sole_requester();
        test_done_idle();
        test_timeout();
        test_abort();
        test_done_expiry();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
